// File: rtl/lsq_mem_arbiter.sv
// lsq_mem_arbiter: arbitrates load/store queue heads onto one req/ack data-memory port.
module lsq_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      async_rst,
  input  logic                      clk_en,
  input  logic                      ld_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
  output logic                      ld_pop,
  input  logic                      st_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]     st_data,
  output logic                      st_pop,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      ld_resp_valid,
  output logic [DATA_WIDTH-1:0]     ld_resp_data,
  output logic                      ld_resp_err,
  output logic                      err_timeout
);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t                    state_q, state_d;
  logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d, ld_resp_data_q, ld_resp_data_d;
  logic                      ld_resp_valid_q, ld_resp_valid_d, ld_resp_err_q, ld_resp_err_d;
  logic                      err_timeout_q, err_timeout_d;
  logic [AW-1:0]             st_age_q, st_age_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      idle, grant_st, grant_ld, ack, tmo_hit;
  always_comb begin
    idle     = state_q == IDLE;
    grant_st = idle & st_valid & (~ld_valid | (st_age_q >= AW'(STARVE_LIMIT)) | (ld_addr == st_addr));
    grant_ld = idle & ld_valid & ~grant_st;
    ld_pop   = clk_en & grant_ld;
    st_pop   = clk_en & grant_st;
    ack      = ~idle & mem_ack;
    // an ack in the final counted cycle wins over the abort
    tmo_hit  = ~idle & ~mem_ack & (tmo_q == TW'(TIMEOUT - 1));
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    ld_resp_valid_d = 1'b0;
    ld_resp_data_d  = ld_resp_data_q;
    ld_resp_err_d   = ld_resp_err_q;
    err_timeout_d   = err_timeout_q | tmo_hit;
    tmo_d           = idle ? '0 : tmo_q + 1'b1;
    if (grant_ld | grant_st) begin
      state_d     = REQ;
      mem_req_d   = 1'b1;
      mem_we_d    = grant_st;
      mem_addr_d  = grant_st ? st_addr : ld_addr;
      mem_wdata_d = grant_st ? st_data : mem_wdata_q;
    end
    if (ack | tmo_hit) begin
      state_d         = IDLE;
      mem_req_d       = 1'b0;
      ld_resp_valid_d = ~mem_we_q;
      ld_resp_err_d   = mem_we_q ? ld_resp_err_q : tmo_hit;
      ld_resp_data_d  = mem_we_q ? ld_resp_data_q : (tmo_hit ? '0 : mem_rdata);
    end
    st_age_d = (~st_valid | grant_st) ? '0 :
               (idle | ~mem_we_q) ? ((st_age_q == AW'(STARVE_LIMIT)) ? st_age_q : st_age_q + 1'b1) :
               st_age_q;
  end
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q         <= IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      ld_resp_valid_q <= 1'b0;
      ld_resp_data_q  <= '0;
      ld_resp_err_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
      st_age_q        <= '0;
      tmo_q           <= '0;
    end else if (clk_en) begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      ld_resp_valid_q <= ld_resp_valid_d;
      ld_resp_data_q  <= ld_resp_data_d;
      ld_resp_err_q   <= ld_resp_err_d;
      err_timeout_q   <= err_timeout_d;
      st_age_q        <= st_age_d;
      tmo_q           <= tmo_d;
    end
  end
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign ld_resp_valid = ld_resp_valid_q;
  assign ld_resp_data  = ld_resp_data_q;
  assign ld_resp_err   = ld_resp_err_q;
  assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// tb_lsq_mem_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_lsq_mem_arbiter;
  logic        clk = 1'b0, async_rst = 1'b1, clk_en = 1'b1;
  logic        ld_valid = 1'b0, st_valid = 1'b0, mem_ack = 1'b0;
  logic [31:0] ld_addr = '0, st_addr = '0, st_data = '0, mem_rdata = '0;
  logic        ld_pop, st_pop, mem_req, mem_we, ld_resp_valid, ld_resp_err, err_timeout;
  logic [31:0] mem_addr, mem_wdata, ld_resp_data;
  int checks = 0, errors = 0;

  lsq_mem_arbiter dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_pop(ld_pop),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pop(st_pop),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_err(ld_resp_err), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv, sv;
    logic [31:0] la, sa, sd;
    logic        e_ld, e_st;
    logic [31:0] e_addr;
  } vec_t;
  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once(input logic [31:0] rd);
    mem_ack = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    v[0] = '{1'b1, 1'b0, 32'h10, 32'h0,  32'h0,  1'b1, 1'b0, 32'h10};
    v[1] = '{1'b0, 1'b1, 32'h0,  32'h20, 32'hAA, 1'b0, 1'b1, 32'h20};
    v[2] = '{1'b1, 1'b1, 32'h30, 32'h34, 32'hBB, 1'b1, 1'b0, 32'h30};
    v[3] = '{1'b1, 1'b1, 32'h50, 32'h50, 32'hCC, 1'b0, 1'b1, 32'h50};
    v[4] = '{1'b0, 1'b0, 32'h60, 32'h64, 32'hDD, 1'b0, 1'b0, 32'h0};
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    tick();
    async_rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      ld_valid = v[i].lv; st_valid = v[i].sv;
      ld_addr = v[i].la; st_addr = v[i].sa; st_data = v[i].sd;
      @(negedge clk);
      chk($sformatf("vec%0d_ld_pop", i), 32'(ld_pop), 32'(v[i].e_ld));
      chk($sformatf("vec%0d_st_pop", i), 32'(st_pop), 32'(v[i].e_st));
      tick();
      ld_valid = 1'b0; st_valid = 1'b0;
      chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(v[i].e_ld | v[i].e_st));
      if (v[i].e_ld | v[i].e_st) begin
        chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(v[i].e_st));
        chk($sformatf("vec%0d_mem_addr", i), mem_addr, v[i].e_addr);
        if (v[i].e_st) chk($sformatf("vec%0d_wdata", i), mem_wdata, v[i].sd);
        ack_once(32'h1000 + i);
        chk($sformatf("vec%0d_req_drop", i), 32'(mem_req), 32'd0);
        chk($sformatf("vec%0d_resp_valid", i), 32'(ld_resp_valid), 32'(v[i].e_ld));
        if (v[i].e_ld) chk($sformatf("vec%0d_resp_data", i), ld_resp_data, 32'h1000 + i);
      end
      tick();
    end

    // single load, ack three cycles after request
    ld_valid = 1'b1; ld_addr = 32'h100;
    @(negedge clk);
    chk("single_ld_pop", 32'(ld_pop), 32'd1);
    tick();
    ld_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("single_req_held", 32'(mem_req), 32'd1);
      chk("single_we", 32'(mem_we), 32'd0);
      chk("single_addr", mem_addr, 32'h100);
      chk("single_no_resp", 32'(ld_resp_valid), 32'd0);
      if (k < 2) tick();
    end
    ack_once(32'hDEADBEEF);
    chk("single_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("single_resp_data", ld_resp_data, 32'hDEADBEEF);
    chk("single_resp_err", 32'(ld_resp_err), 32'd0);
    chk("single_req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("single_resp_one_cycle", 32'(ld_resp_valid), 32'd0);

    // starvation: four loads age the store to the limit, then the store goes, then a load
    ld_valid = 1'b1; st_valid = 1'b1; ld_addr = 32'h200; st_addr = 32'h300; st_data = 32'h77;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_ld_pop", g), 32'(ld_pop), 32'(g != 4));
      chk($sformatf("starve%0d_st_pop", g), 32'(st_pop), 32'(g == 4));
      tick();
      chk($sformatf("starve%0d_we", g), 32'(mem_we), 32'(g == 4));
      ack_once(32'h2000 + g);
    end
    ld_valid = 1'b0; st_valid = 1'b0;
    tick();

    // address hazard: store first, then load
    ld_valid = 1'b1; st_valid = 1'b1; ld_addr = 32'h40; st_addr = 32'h40; st_data = 32'h55;
    @(negedge clk);
    chk("hazard_st_pop", 32'(st_pop), 32'd1);
    chk("hazard_ld_held", 32'(ld_pop), 32'd0);
    tick();
    st_valid = 1'b0;
    chk("hazard_we", 32'(mem_we), 32'd1);
    chk("hazard_wdata", mem_wdata, 32'h55);
    ack_once(32'h0);
    chk("hazard_no_resp", 32'(ld_resp_valid), 32'd0);
    @(negedge clk);
    chk("hazard_ld_pop", 32'(ld_pop), 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("hazard_ld_we", 32'(mem_we), 32'd0);
    chk("hazard_wdata_held", mem_wdata, 32'h55);
    ack_once(32'h4444);
    chk("hazard_ld_data", ld_resp_data, 32'h4444);
    tick();

    // timeout on a load that is never acked
    ld_valid = 1'b1; ld_addr = 32'h500;
    tick();
    ld_valid = 1'b0;
    cnt = 0;
    while (mem_req && cnt < 1000) begin
      cnt++;
      tick();
    end
    chk("tmo_req_cycles", 32'(cnt), 32'd255);
    chk("tmo_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("tmo_resp_err", 32'(ld_resp_err), 32'd1);
    chk("tmo_resp_data", ld_resp_data, 32'd0);
    chk("tmo_err_flag", 32'(err_timeout), 32'd1);
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h99;
    @(negedge clk);
    chk("post_tmo_st_pop", 32'(st_pop), 32'd1);
    tick();
    st_valid = 1'b0;
    chk("post_tmo_req", 32'(mem_req), 32'd1);
    ack_once(32'h0);
    chk("post_tmo_sticky", 32'(err_timeout), 32'd1);
    tick();

    // clk_en low: pops suppressed in IDLE, REQ frozen
    clk_en = 1'b0; ld_valid = 1'b1; ld_addr = 32'h700;
    @(negedge clk);
    chk("cen_idle_no_pop", 32'(ld_pop), 32'd0);
    tick();
    chk("cen_idle_no_req", 32'(mem_req), 32'd0);
    clk_en = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("cen_req", 32'(mem_req), 32'd1);
    clk_en = 1'b0; ld_valid = 1'b1; st_valid = 1'b1; st_addr = 32'h704;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("cen_frozen_pops", 32'({ld_pop, st_pop}), 32'd0);
      tick();
      chk("cen_frozen_req", 32'(mem_req), 32'd1);
      chk("cen_frozen_addr", mem_addr, 32'h700);
    end
    ld_valid = 1'b0; st_valid = 1'b0; clk_en = 1'b1;
    tick();
    ack_once(32'h7777);
    chk("cen_resume_resp", 32'(ld_resp_valid), 32'd1);
    chk("cen_resume_data", ld_resp_data, 32'h7777);
    tick();

    // asynchronous reset during REQ, late ack ignored
    st_valid = 1'b1; st_addr = 32'h800; st_data = 32'h88;
    tick();
    st_valid = 1'b0;
    chk("ar_req_before", 32'(mem_req), 32'd1);
    #2 async_rst = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_we", 32'(mem_we), 32'd0);
    chk("ar_addr", mem_addr, 32'd0);
    chk("ar_wdata", mem_wdata, 32'd0);
    chk("ar_err_timeout", 32'(err_timeout), 32'd0);
    tick();
    async_rst = 1'b0;
    ack_once(32'h9999);
    chk("ar_late_ack_req", 32'(mem_req), 32'd0);
    chk("ar_late_ack_resp", 32'(ld_resp_valid), 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h900;
    @(negedge clk);
    chk("ar_idle_grant", 32'(ld_pop), 32'd1);
    tick();
    ld_valid = 1'b0;
    ack_once(32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsq_mem_arbiter.md
Name: lsq_mem_arbiter

Overview:
Sequences the load/store queue onto the single data-memory port. It takes a load-head request and a committed-store-head request and picks one per transaction. It drives a req/ack memory handshake, pops the winning queue head and returns load data. Loads have priority except on address hazards and store starvation. A response timeout guards against a hung memory.

Parameters:
MEM_ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width
STARVE_LIMIT, 8, cycles a store may lose arbitration before it is forced through (>=1)
TIMEOUT, 255, cycles in REQ without mem_ack before abort (>=1)

Ports:
clk  in  1  clock
async_rst  in  1  asynchronous active-high reset
clk_en  in  1  global clock enable; 0 freezes all state
ld_valid  in  1  load queue head is valid
ld_addr  in  MEM_ADDR_WIDTH  load head address
ld_pop  out  1  pops the load head (one-cycle pulse)
st_valid  in  1  committed store head is valid
st_addr  in  MEM_ADDR_WIDTH  store head address
st_data  in  DATA_WIDTH  store head data
st_pop  out  1  pops the store head (one-cycle pulse)
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
ld_resp_valid  out  1  load response strobe, one cycle
ld_resp_data  out  DATA_WIDTH  load response data
ld_resp_err  out  1  load response was aborted by timeout
err_timeout  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async_rst=1): state goes to IDLE immediately. All outputs go to 0, including mem_req, mem_we, mem_addr, mem_wdata, ld_resp_*, err_timeout. st_age and the timeout counter clear. mem_req drops without waiting for ack; a late ack after reset is ignored.
- clk_en=0: state, counters and registered outputs hold. ld_pop and st_pop are forced to 0. A mem_ack arriving while clk_en=0 is lost; the system guarantees this does not happen.
- The FSM has two states, IDLE and REQ.
- IDLE, arbitration is combinational and applies when clk_en=1:
  - Only one of ld_valid/st_valid is high: that side wins.
  - Both high: store wins if st_age >= STARVE_LIMIT or ld_addr == st_addr (RAW/WAR hazard). Otherwise load wins.
  - Neither high: stay in IDLE, no pops.
- Grant in cycle N:
  - ld_pop or st_pop is asserted combinationally in cycle N.
  - mem_addr, mem_we and mem_wdata are registered at the N edge. For a load, mem_wdata holds its previous value.
  - mem_req=1 from cycle N+1. State moves to REQ.
- REQ: mem_req, mem_we, mem_addr and mem_wdata are held stable. No new grant.
- mem_ack received in REQ, cycle M:
  - mem_req goes 0 at M+1 and state returns to IDLE. A new grant is possible in cycle M+1, so the minimum back-to-back spacing is 2 cycles/transaction.
  - If the transaction was a read: ld_resp_valid=1, ld_resp_data=mem_rdata captured at M, ld_resp_err=0, all in cycle M+1 only.
  - If it was a write: no response.
- Timeout: the counter clears on entering REQ and increments each clk_en cycle in REQ.
  - When it reaches TIMEOUT without an ack: mem_req goes 0 next cycle, err_timeout is set, and state returns to IDLE.
  - If the aborted transaction was a read: ld_resp_valid=1, ld_resp_err=1, ld_resp_data=0.
  - mem_ack in the same cycle the counter reaches TIMEOUT counts as success.
- st_age counter:
  - Width is $clog2(STARVE_LIMIT+1); it saturates at STARVE_LIMIT.
  - Increments on each clk_en cycle in IDLE where st_valid=1 and the store is not granted.
  - Also increments in REQ while a load is in flight and st_valid=1.
  - Clears on store grant or when st_valid=0.
- The address comparison is the full MEM_ADDR_WIDTH equality. The input queues never change a head while it is not popped.

Test Plan:
- Single load: ld_valid=1, ld_addr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> ld_pop in grant cycle, mem_req/mem_we=0/mem_addr=0x100 held until ack, ld_resp_valid=1 with data 0xDEADBEEF one cycle after ack.
- Load priority vs. starvation: ld_valid and st_valid held high, distinct addrs, ack 1 cycle after req -> load wins repeatedly until st_age reaches 8, then the next grant is the store (mem_we=1, st_pop=1), after which st_age=0.
- Hazard: ld_addr=st_addr=0x40, st_data=0x55, st_age=0 -> store granted first, then the load.
- Timeout: grant a load, never ack -> mem_req drops after 255 REQ cycles, err_timeout=1, ld_resp_valid=1 with ld_resp_err=1; the next request arbitrates normally.
- Reset mid-REQ: assert async_rst while mem_req=1 -> mem_req and all outputs 0 without a clock edge, FSM in IDLE after release.
- clk_en=0 for 5 cycles in REQ with no ack -> no pops, outputs and timeout counter frozen; the transaction resumes when clk_en=1.
